// File: rtl/servant_tick_sched.sv
// servant_tick_sched: drift-free periodic tick driven from the servant timer over Wishbone
module servant_tick_sched #(
    parameter int CMP_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [CMP_WIDTH-1:0] i_period,
    output logic                 o_wb_cyc,
    output logic                 o_wb_we,
    output logic [31:0]          o_wb_dat,
    input  logic [31:0]          i_wb_dat,
    input  logic                 i_wb_ack,
    input  logic                 i_irq,
    output logic                 o_tick,
    output logic [CNT_WIDTH-1:0] o_tick_cnt,
    output logic [CNT_WIDTH-1:0] o_missed
);
    localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, WR = 3'd2, SETTLE = 3'd3, WAIT = 3'd4;
    logic [2:0]           state;
    logic [CMP_WIDTH-1:0] period, last_cmp, now, late, nxt;
    logic                 first, settle, late_miss, unused;
    assign now       = i_wb_dat[CMP_WIDTH-1:0];
    assign unused    = ^i_wb_dat[31:CMP_WIDTH];
    assign late      = now - last_cmp;
    assign late_miss = !first && late >= period;
    // On time: stay on the original grid; late or first arm: restart from now
    assign nxt       = (first || late_miss) ? now + period : last_cmp + period;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            o_wb_cyc   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_dat   <= '0;
            o_tick     <= 1'b0;
            o_tick_cnt <= '0;
            o_missed   <= '0;
            period     <= '0;
            last_cmp   <= '0;
            first      <= 1'b1;
            settle     <= 1'b0;
        end else begin
            o_tick <= 1'b0;
            case (state)
                IDLE: if (i_en && i_period != '0) begin
                    state    <= RD;
                    period   <= i_period;
                    first    <= 1'b1;
                    o_wb_cyc <= 1'b1;
                    o_wb_we  <= 1'b0;
                end
                RD: if (i_wb_ack) begin
                    o_wb_dat <= 32'(nxt);
                    o_missed <= o_missed + CNT_WIDTH'(late_miss && !(&o_missed));
                    o_wb_cyc <= i_en;
                    o_wb_we  <= i_en;
                    state    <= i_en ? WR : IDLE;
                end
                WR: if (i_wb_ack) begin
                    last_cmp <= o_wb_dat[CMP_WIDTH-1:0];
                    first    <= 1'b0;
                    o_wb_cyc <= 1'b0;
                    o_wb_we  <= 1'b0;
                    settle   <= 1'b0;
                    state    <= i_en ? SETTLE : IDLE;
                end
                // The timer's registered compare still reflects the old mtimecmp here
                SETTLE: begin
                    settle <= 1'b1;
                    if (settle) state <= WAIT;
                end
                WAIT: if (!i_en) state <= IDLE;
                else if (i_irq) begin
                    o_tick     <= 1'b1;
                    o_tick_cnt <= o_tick_cnt + CNT_WIDTH'(1);
                    o_wb_cyc   <= 1'b1;
                    o_wb_we    <= 1'b0;
                    state      <= RD;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/servant_tick_sched.md
# servant_tick_sched

Wishbone initiator that drives the servant machine timer from the other side of its bus port and turns its level interrupt into a periodic, drift-free tick. It reads `mtime`, programs `mtimecmp` one period ahead, waits for the timer IRQ, emits a one-cycle tick, then re-arms. It sits between the timer's Wishbone port and any consumer needing a hardware heartbeat, such as a watchdog or a sampling strobe, so no CPU interrupt service is required.

## Interface
- `CMP_WIDTH`, 16: significant timer bits (timer WIDTH minus DIVIDER). All compare arithmetic is modulo 2^CMP_WIDTH.
- `CNT_WIDTH`, 16: width of tick and missed-deadline counters.

- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_en` in 1: scheduler enable (level).
- `i_period` in CMP_WIDTH: tick period in timer units; sampled when arming.
- `o_wb_cyc` in-to-timer out 1: bus cycle request, held until ack.
- `o_wb_we` out 1: 1 = write `mtimecmp`, 0 = read `mtime`.
- `o_wb_dat` out 32: write data; bits above CMP_WIDTH are zero.
- `i_wb_dat` in 32: read data; only [CMP_WIDTH-1:0] used.
- `i_wb_ack` in 1: one-cycle acknowledge from the bus mux.
- `i_irq` in 1: timer interrupt (`mtime >= mtimecmp`, registered in timer).
- `o_tick` out 1: one-cycle pulse per serviced deadline.
- `o_tick_cnt` out CNT_WIDTH: ticks emitted, wrapping.
- `o_missed` out CNT_WIDTH: deadlines found late, saturating at all-ones.

## Operation
- States: IDLE, RD (read `mtime`), WR (write `mtimecmp`), SETTLE (2-cycle IRQ blanking), WAIT.
- IDLE → RD when `i_en`=1 and `i_period`≠0. Latch `period`; set flag `first`=1.
- RD:
  - cyc=1 and we=0 until ack.
  - On ack, latch `now` = i_wb_dat[CMP_WIDTH-1:0].
  - If `first`: `next` = now + period.
  - Otherwise compute `late` = now − last_cmp (mod 2^CMP_WIDTH).
    - If `late` < period: `next` = last_cmp + period. This is drift-free.
    - Else: `next` = now + period, and increment `o_missed`.
  - Go to WR.
- WR: cyc=1, we=1, dat=`next` until ack. On ack, set `last_cmp` = next and `first`=0, then go to SETTLE.
- SETTLE: ignore `i_irq` for exactly 2 cycles, to cover the timer's registered compare of the stale `mtimecmp`. Then go to WAIT.
- WAIT:
  - If `i_en`=0, go to IDLE.
  - Else if `i_irq`=1, pulse `o_tick`, increment `o_tick_cnt`, and go to RD.
- `i_en` falling in RD or WR: the bus cycle still completes on ack, then the block goes to IDLE. Cyc is never dropped without ack, except on reset.
- `i_period`=0 while enabled: IDLE stays idle with no bus traffic. The period is only resampled on IDLE → RD.
- Wrap: `next` wraps modulo 2^CMP_WIDTH. The timer's compare is unsigned, so if `next` wraps below `mtime`, IRQ fires immediately. This is counted as a normal tick, not a miss.

## Timing
- Reset values:
  - State = IDLE.
  - `o_wb_cyc`=0, `o_wb_we`=0, `o_wb_dat`=0.
  - `o_tick`=0, `o_tick_cnt`=0, `o_missed`=0.
  - `last_cmp`=0, `first`=1.
- Reset mid-transaction deasserts `o_wb_cyc` on the next edge.
- All outputs are registered. `o_wb_cyc` rises 1 cycle after the IDLE→RD decision.
- Ack-to-next-request is 1 cycle: RD ack at edge N gives WR cyc at N+1.
- Arming with 1-cycle ack: RD(1) + WR(1) + SETTLE(2) gives WAIT 4 cycles after leaving IDLE.
- `o_tick` is asserted the cycle after `i_irq` is sampled high in WAIT. It lasts 1 cycle, and `o_tick_cnt` updates in the same cycle.
- `o_missed` updates in the cycle after RD ack.

## Test plan
- Arm with period=100, `mtime` read=0x0010, ack after 1 cycle → write `o_wb_dat`=0x0074; no tick before `i_irq`.
- Steady state: with `last_cmp`=0x0074, assert irq and read `now`=0x0076 → write 0x00D8 (drift-free), `o_tick` for 1 cycle, `o_tick_cnt`=1, `o_missed`=0.
- Late deadline: with `last_cmp`=0x00D8, period=100, read `now`=0x0140 → write 0x01A4, `o_missed`=1.
- Wrap: with `last_cmp`=0xFFD0, period=0x60, not late → write 0x0030. The immediate irq yields a tick, `o_missed` unchanged.
- Stale IRQ: hold `i_irq`=1 through WR ack and 1 cycle after → no second tick during SETTLE. An irq still high in WAIT triggers a tick.
- Control edges:
  - Drop `i_en` mid-WR with ack delayed 3 cycles → cyc held until ack, then IDLE.
  - Period=0 → no bus cycles.
  - `i_rst` mid-RD → cyc=0 next edge, all counters 0.
